// File: rtl/riscv_ahb_biu.sv
// AHB3-Lite master bus interface for the RISC-V memory access buffer.
// Two-entry pipeline: address-phase register A and data-phase register D.
//
// err state | meaning
// ERR_IDLE  | normal operation
// ERR_PEND  | first ERROR cycle seen, waiting for the HREADY=1 second cycle
module riscv_ahb_biu #(
    parameter int         PLEN      = 64,
    parameter int         XLEN      = 64,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            biu_stb_i,
    output logic            biu_stb_ack_o,
    input  logic [PLEN-1:0] biu_adr_i,
    input  logic [2:0]      biu_size_i,
    input  logic            biu_we_i,
    input  logic [XLEN-1:0] biu_d_i,
    output logic [XLEN-1:0] biu_q_o,
    output logic            biu_ack_o,
    output logic            biu_err_o,

    output logic            HSEL,
    output logic [PLEN-1:0] HADDR,
    output logic [XLEN-1:0] HWDATA,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [3:0]      HPROT,
    output logic [1:0]      HTRANS,
    output logic            HMASTLOCK,
    input  logic [XLEN-1:0] HRDATA,
    input  logic            HREADY,
    input  logic            HRESP
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic {
        ERR_IDLE,
        ERR_PEND
    } err_state_e;

    err_state_e err_state_q, err_state_d;

    logic            a_valid_q, a_valid_d;
    logic [PLEN-1:0] a_adr_q,   a_adr_d;
    logic [2:0]      a_size_q,  a_size_d;
    logic            a_we_q,    a_we_d;
    logic [XLEN-1:0] a_wdata_q, a_wdata_d;

    logic            d_valid_q, d_valid_d;
    logic            d_we_q,    d_we_d;

    logic [XLEN-1:0] hwdata_q,  hwdata_d;
    logic [1:0]      htrans_q,  htrans_d;
    logic            hsel_q,    hsel_d;

    logic            ack_q,     ack_d;
    logic            err_q,     err_d;
    logic [XLEN-1:0] rdata_q,   rdata_d;

    logic            err_pend;
    logic            drop_a;
    logic            stb_ack;
    logic            a_adv;
    logic            d_done;

    assign a_adv   = a_valid_q & HREADY;
    assign d_done  = d_valid_q & HREADY;
    assign stb_ack = rst_ni & biu_stb_i & (~a_valid_q | HREADY) & ~err_pend;

    // Error FSM: state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_state_q <= ERR_IDLE;
        end else begin
            err_state_q <= err_state_d;
        end
    end

    // Error FSM: next state
    always_comb begin
        err_state_d = err_state_q;
        if (err_state_q == ERR_IDLE) begin
            if (d_valid_q & HRESP & ~HREADY) begin
                err_state_d = ERR_PEND;
            end
        end else if (d_done) begin
            err_state_d = ERR_IDLE;
        end
    end

    // Error FSM: outputs
    always_comb begin
        err_pend = (err_state_q == ERR_PEND);
        drop_a   = (err_state_q == ERR_IDLE) & d_valid_q & HRESP & ~HREADY;
    end

    always_comb begin
        a_valid_d = a_valid_q;
        a_adr_d   = a_adr_q;
        a_size_d  = a_size_q;
        a_we_d    = a_we_q;
        a_wdata_d = a_wdata_q;
        d_valid_d = d_valid_q;
        d_we_d    = d_we_q;
        hwdata_d  = hwdata_q;
        rdata_d   = rdata_q;

        if (a_adv) begin
            a_valid_d = 1'b0;
        end
        if (stb_ack) begin
            a_valid_d = 1'b1;
            a_adr_d   = biu_adr_i;
            a_size_d  = biu_size_i;
            a_we_d    = biu_we_i;
            a_wdata_d = biu_d_i;
        end
        // The slave's first ERROR cycle cancels whatever sits in the address phase.
        if (drop_a) begin
            a_valid_d = 1'b0;
        end

        if (d_done) begin
            d_valid_d = 1'b0;
        end
        if (a_adv) begin
            d_valid_d = 1'b1;
            d_we_d    = a_we_q;
            if (a_we_q) begin
                hwdata_d = a_wdata_q;
            end
        end

        htrans_d = a_valid_d ? HTRANS_NONSEQ : HTRANS_IDLE;
        hsel_d   = a_valid_d;

        ack_d = d_done & ~HRESP;
        err_d = d_done & HRESP;
        if (d_done & ~HRESP & ~d_we_q) begin
            rdata_d = HRDATA;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            a_valid_q <= 1'b0;
            a_adr_q   <= '0;
            a_size_q  <= '0;
            a_we_q    <= 1'b0;
            a_wdata_q <= '0;
            d_valid_q <= 1'b0;
            d_we_q    <= 1'b0;
            hwdata_q  <= '0;
            htrans_q  <= HTRANS_IDLE;
            hsel_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            a_valid_q <= a_valid_d;
            a_adr_q   <= a_adr_d;
            a_size_q  <= a_size_d;
            a_we_q    <= a_we_d;
            a_wdata_q <= a_wdata_d;
            d_valid_q <= d_valid_d;
            d_we_q    <= d_we_d;
            hwdata_q  <= hwdata_d;
            htrans_q  <= htrans_d;
            hsel_q    <= hsel_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign biu_stb_ack_o = stb_ack;
    assign biu_ack_o     = ack_q;
    assign biu_err_o     = err_q;
    assign biu_q_o       = rdata_q;

    assign HSEL      = hsel_q;
    assign HADDR     = a_adr_q;
    assign HWDATA    = hwdata_q;
    assign HWRITE    = a_we_q;
    assign HSIZE     = a_size_q;
    assign HTRANS    = htrans_q;
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_riscv_ahb_biu.sv
// Self-checking bench for riscv_ahb_biu: transaction-queue model checked every cycle
// plus directed literal expectations for each scenario.
module tb_riscv_ahb_biu;

    logic        clk;
    logic        rst_n;
    logic        stb;
    logic [63:0] adr;
    logic [2:0]  size;
    logic        we;
    logic [63:0] d;
    logic [63:0] hrdata;
    logic        hready;
    logic        hresp;

    logic        biu_stb_ack;
    logic [63:0] biu_q;
    logic        biu_ack;
    logic        biu_err;
    logic        hsel;
    logic [63:0] haddr;
    logic [63:0] hwdata;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;

    int n_chk  = 0;
    int n_pass = 0;

    riscv_ahb_biu dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .biu_stb_i     (stb),
        .biu_stb_ack_o (biu_stb_ack),
        .biu_adr_i     (adr),
        .biu_size_i    (size),
        .biu_we_i      (we),
        .biu_d_i       (d),
        .biu_q_o       (biu_q),
        .biu_ack_o     (biu_ack),
        .biu_err_o     (biu_err),
        .HSEL          (hsel),
        .HADDR         (haddr),
        .HWDATA        (hwdata),
        .HWRITE        (hwrite),
        .HSIZE         (hsize),
        .HBURST        (hburst),
        .HPROT         (hprot),
        .HTRANS        (htrans),
        .HMASTLOCK     (hmastlock),
        .HRDATA        (hrdata),
        .HREADY        (hready),
        .HRESP         (hresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Model: outstanding transfers in issue order; dph marks one already in its data phase.
    typedef struct {
        logic [63:0] adr;
        logic        we;
        logic [63:0] wd;
        bit          dph;
    } txn_t;

    txn_t        pipe[$];
    logic [63:0] m_haddr  = '0;
    logic [63:0] m_hwdata = '0;
    logic [63:0] m_q      = '0;
    logic        m_hwrite = 1'b0;
    logic [2:0]  m_hsize  = '0;
    bit          m_ack    = 1'b0;
    bit          m_err    = 1'b0;
    bit          m_errpend = 1'b0;

    function automatic bit m_has_addr();
        foreach (pipe[i]) if (!pipe[i].dph) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_stb_ack();
        return rst_n && stb && (!m_has_addr() || hready) && !m_errpend;
    endfunction

    always @(posedge clk) begin : model
        bit acc;
        bit dropped;
        acc     = m_stb_ack();
        dropped = 1'b0;
        m_ack   = 1'b0;
        m_err   = 1'b0;
        if (!rst_n) begin
            pipe.delete();
            m_haddr   = '0;
            m_hwdata  = '0;
            m_q       = '0;
            m_hwrite  = 1'b0;
            m_hsize   = '0;
            m_errpend = 1'b0;
        end else begin
            if (pipe.size() != 0 && pipe[0].dph) begin
                if (hready) begin
                    if (hresp) m_err = 1'b1;
                    else begin
                        m_ack = 1'b1;
                        if (!pipe[0].we) m_q = hrdata;
                    end
                    m_errpend = 1'b0;
                    void'(pipe.pop_front());
                end else if (hresp && !m_errpend) begin
                    m_errpend = 1'b1;
                    while (pipe.size() > 1) void'(pipe.pop_back());
                    dropped = 1'b1;
                end
            end
            if (hready) begin
                foreach (pipe[i]) begin
                    if (!pipe[i].dph) begin
                        pipe[i].dph = 1'b1;
                        if (pipe[i].we) m_hwdata = pipe[i].wd;
                    end
                end
            end
            if (acc) begin
                m_haddr  = adr;
                m_hwrite = we;
                m_hsize  = size;
                if (!dropped) pipe.push_back('{adr, we, d, 1'b0});
            end
        end
    end

    always @(negedge clk) begin
        chk("stb_ack",   64'(biu_stb_ack), 64'(m_stb_ack()));
        chk("htrans",    64'(htrans),      64'(m_has_addr() ? 2 : 0));
        chk("hsel",      64'(hsel),        64'(m_has_addr()));
        chk("haddr",     haddr,            m_haddr);
        chk("hwrite",    64'(hwrite),      64'(m_hwrite));
        chk("hsize",     64'(hsize),       64'(m_hsize));
        chk("hwdata",    hwdata,           m_hwdata);
        chk("ack",       64'(biu_ack),     64'(m_ack));
        chk("err",       64'(biu_err),     64'(m_err));
        chk("q",         biu_q,            m_q);
        chk("hburst",    64'(hburst),      64'd0);
        chk("hprot",     64'(hprot),       64'd3);
        chk("hmastlock", 64'(hmastlock),   64'd0);
    end

    task automatic cyc(input bit r, input bit s, input logic [63:0] a, input logic [2:0] sz,
                       input bit w, input logic [63:0] dd, input bit rdy, input bit rsp,
                       input logic [63:0] rd);
        @(posedge clk);
        #1;
        rst_n  = r;
        stb    = s;
        adr    = a;
        size   = sz;
        we     = w;
        d      = dd;
        hready = rdy;
        hresp  = rsp;
        hrdata = rd;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1, 0, 64'h0, 3'd0, 0, 64'h0, 1, 0, 64'h0);
    endtask

    initial begin
        rst_n = 1'b0; stb = 1'b0; adr = '0; size = '0; we = 1'b0; d = '0;
        hready = 1'b1; hresp = 1'b0; hrdata = '0;

        // reset, with a request pending that must not be acknowledged
        cyc(0, 1, 64'h9000, 3'd2, 0, 64'h0, 1, 0, 64'h0);
        cyc(0, 1, 64'h9000, 3'd2, 0, 64'h0, 1, 0, 64'h0);
        chk("L_rst_stb_ack", 64'(biu_stb_ack), 64'd0);
        chk("L_rst_htrans",  64'(htrans), 64'd0);
        chk("L_rst_haddr",   haddr, 64'd0);
        chk("L_rst_q",       biu_q, 64'd0);

        // single read
        cyc(1, 1, 64'h1000, 3'd2, 0, 64'h0, 1, 0, 64'h0);
        chk("L_rd_stb_ack", 64'(biu_stb_ack), 64'd1);
        cyc(1, 0, 64'h0, 3'd0, 0, 64'h0, 1, 0, 64'h0);
        chk("L_rd_nonseq", 64'(htrans), 64'd2);
        chk("L_rd_haddr",  haddr, 64'h1000);
        cyc(1, 0, 64'h0, 3'd0, 0, 64'h0, 1, 0, 64'hDEADBEEF);
        chk("L_rd_idle", 64'(htrans), 64'd0);
        idle();
        chk("L_rd_ack", 64'(biu_ack), 64'd1);
        chk("L_rd_q",   biu_q, 64'hDEADBEEF);

        // four back-to-back writes
        for (int i = 0; i < 8; i++) begin
            cyc(1, i < 4, 64'h2000 + 64'(8 * i), 3'd3, 1, 64'(i + 1), 1, 0, 64'h0);
            if (i < 4) chk("L_wr_stb_ack", 64'(biu_stb_ack), 64'd1);
            if (i >= 2 && i < 6) chk("L_wr_hwdata", hwdata, 64'(i - 1));
            if (i >= 3 && i < 7) chk("L_wr_ack", 64'(biu_ack), 64'd1);
        end

        // read with three data-phase wait states, second read fills A meanwhile
        cyc(1, 1, 64'h4000, 3'd2, 0, 64'h0, 1, 0, 64'h0);
        cyc(1, 0, 64'h0, 3'd0, 0, 64'h0, 1, 0, 64'h0);
        cyc(1, 1, 64'h4008, 3'd2, 0, 64'h0, 0, 0, 64'h0);
        chk("L_ws_stb_ack_free", 64'(biu_stb_ack), 64'd1);
        for (int i = 0; i < 2; i++) begin
            cyc(1, 1, 64'h4008, 3'd2, 0, 64'h0, 0, 0, 64'h0);
            chk("L_ws_stb_ack_full", 64'(biu_stb_ack), 64'd0);
            chk("L_ws_htrans", 64'(htrans), 64'd2);
            chk("L_ws_haddr",  haddr, 64'h4008);
        end
        cyc(1, 0, 64'h0, 3'd0, 0, 64'h0, 1, 0, 64'h55);
        chk("L_ws_haddr_last", haddr, 64'h4008);
        chk("L_ws_no_ack",     64'(biu_ack), 64'd0);
        cyc(1, 0, 64'h0, 3'd0, 0, 64'h0, 1, 0, 64'h66);
        chk("L_ws_ack1", 64'(biu_ack), 64'd1);
        chk("L_ws_q1",   biu_q, 64'h55);
        idle();
        chk("L_ws_ack2", 64'(biu_ack), 64'd1);
        chk("L_ws_q2",   biu_q, 64'h66);
        idle();

        // two pipelined reads, first one gets a two-cycle ERROR
        cyc(1, 1, 64'h3000, 3'd2, 0, 64'h0, 1, 0, 64'h0);
        cyc(1, 1, 64'h3008, 3'd2, 0, 64'h0, 1, 0, 64'h0);
        chk("L_er_stb_ack", 64'(biu_stb_ack), 64'd1);
        cyc(1, 0, 64'h0, 3'd0, 0, 64'h0, 0, 1, 64'h0);
        chk("L_er_htrans_busy", 64'(htrans), 64'd2);
        chk("L_er_haddr", haddr, 64'h3008);
        cyc(1, 1, 64'h3010, 3'd2, 0, 64'h0, 1, 1, 64'h0);
        chk("L_er_htrans_idle", 64'(htrans), 64'd0);
        chk("L_er_stb_blocked", 64'(biu_stb_ack), 64'd0);
        idle();
        chk("L_er_err", 64'(biu_err), 64'd1);
        chk("L_er_no_ack", 64'(biu_ack), 64'd0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("L_er_quiet_ack", 64'(biu_ack), 64'd0);
            chk("L_er_quiet_err", 64'(biu_err), 64'd0);
        end

        // reset asserted during a write's data phase
        cyc(1, 1, 64'h5000, 3'd3, 1, 64'h77, 1, 0, 64'h0);
        cyc(1, 0, 64'h0, 3'd0, 0, 64'h0, 1, 0, 64'h0);
        cyc(0, 1, 64'h5008, 3'd3, 1, 64'h88, 0, 0, 64'h0);
        chk("L_mr_hwdata", hwdata, 64'h77);
        chk("L_mr_stb_ack", 64'(biu_stb_ack), 64'd0);
        cyc(1, 0, 64'h0, 3'd0, 0, 64'h0, 1, 0, 64'hAA);
        chk("L_mr_hwdata0", hwdata, 64'd0);
        chk("L_mr_haddr0",  haddr, 64'd0);
        chk("L_mr_hwrite0", 64'(hwrite), 64'd0);
        chk("L_mr_hsize0",  64'(hsize), 64'd0);
        chk("L_mr_htrans0", 64'(htrans), 64'd0);
        chk("L_mr_q0",      biu_q, 64'd0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("L_mr_no_ack", 64'(biu_ack), 64'd0);
            chk("L_mr_no_err", 64'(biu_err), 64'd0);
        end

        // idle bus
        for (int i = 0; i < 10; i++) begin
            idle();
            chk("L_id_htrans", 64'(htrans), 64'd0);
            chk("L_id_hsel",   64'(hsel), 64'd0);
            chk("L_id_ack",    64'(biu_ack), 64'd0);
            chk("L_id_err",    64'(biu_err), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/riscv_ahb_biu.md
RISCV_AHB_BIU -- requirements
Module: riscv_ahb_biu

Interface
REQ-001 Parameter PLEN, default 64: physical address width.
REQ-002 Parameter XLEN, default 64: data width; 32 or 64.
REQ-003 Parameter HPROT_VAL, default 4'b0011: fixed HPROT value (data, privileged).
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 rst_ni  in  1  reset, synchronous, active-low.
REQ-006 biu_stb_i  in  1  CPU-side request (driven by memory access buffer req_o).
REQ-007 biu_stb_ack_o  out  1  request accepted this cycle (feeds buffer ack_i).
REQ-008 biu_adr_i  in  PLEN  request address.
REQ-009 biu_size_i  in  3  AHB HSIZE encoding of transfer.
REQ-010 biu_we_i  in  1  1=write, 0=read.
REQ-011 biu_d_i  in  XLEN  write data, sampled with accepted request.
REQ-012 biu_q_o  out  XLEN  read data, valid while biu_ack_o=1.
REQ-013 biu_ack_o  out  1  one-cycle pulse: transfer completed OK.
REQ-014 biu_err_o  out  1  one-cycle pulse: transfer completed with ERROR.
REQ-015 HSEL, HADDR[PLEN], HWDATA[XLEN], HWRITE, HSIZE[3], HBURST[3], HPROT[4], HTRANS[2], HMASTLOCK  out  AHB3-Lite master outputs, all registered.
REQ-016 HRDATA[XLEN], HREADY, HRESP  in  AHB3-Lite master inputs.

Function
REQ-017 Two-stage pipeline: address-phase register (A) and data-phase register (D), each with valid bit.
REQ-018 biu_stb_ack_o = biu_stb_i & (~A.valid | HREADY) & ~err_pend; combinational.
REQ-019 On stb_ack: A loads adr/size/we/d_i; HTRANS=NONSEQ(2'b10), HSEL=1 next cycle.
REQ-020 No accepted request with A free: HTRANS=IDLE(2'b00), HSEL=0; HADDR/HWRITE/HSIZE hold last value.
REQ-021 HBURST=SINGLE(3'b000), HMASTLOCK=0, HPROT=HPROT_VAL constantly.
REQ-022 A advances to D when A.valid & HREADY; HWDATA is driven from A's stored write data in same edge, held stable during data phase.
REQ-023 Back-to-back: new A load and A->D move in same cycle allowed; sustained throughput one transfer/cycle with HREADY=1.
REQ-024 Wait states: HREADY=0 freezes A, D, and all AHB outputs.
REQ-025 D completes when D.valid & HREADY & ~HRESP: next cycle biu_ack_o=1 for one cycle; biu_q_o=HRDATA registered for reads, unchanged for writes.
REQ-026 Latency: stb accepted cycle N, zero wait states -> address phase N+1, data phase N+2, biu_ack_o N+3.
REQ-027 Error: HRESP=1 & HREADY=0 with D.valid (first error cycle) -> set err_pend, drive HTRANS=IDLE next cycle, drop A (cancelled, no ack/err for it).
REQ-028 Error second cycle HRESP=1 & HREADY=1 -> biu_err_o=1 next cycle for one cycle, D cleared, err_pend cleared.
REQ-029 biu_ack_o and biu_err_o never both 1; at most one completion pulse per accepted request, except cancelled A per REQ-027.
REQ-030 Cancelled requests are lost; requester re-issues them.
REQ-031 Max outstanding: 2 (A + D); biu_stb_ack_o=0 while both valid and HREADY=0.

Reset
REQ-032 rst_ni=0 sampled at clk_i: A.valid=D.valid=err_pend=0, HTRANS=IDLE, HSEL=0, HWRITE=0, HADDR=0, HWDATA=0, HSIZE=0, biu_ack_o=0, biu_err_o=0, biu_q_o=0.
REQ-033 biu_stb_ack_o=0 while rst_ni=0.
REQ-034 Reset mid-transfer drops A and D; no ack/err generated afterwards for them.

Verification
REQ-035 Single read, adr=0x1000, HREADY=1, HRDATA=0xDEADBEEF -> HTRANS=NONSEQ at N+1, biu_ack_o=1 and biu_q_o=0xDEADBEEF at N+3.
REQ-036 Four back-to-back writes d=1..4, HREADY=1 -> stb_ack each cycle, HWDATA=1,2,3,4 in consecutive data phases, four ack pulses consecutive.
REQ-037 Read with HREADY=0 for 3 cycles in data phase -> AHB outputs stable, stb_ack=0 once A full, ack 1 cycle after HREADY returns.
REQ-038 Two pipelined reads, first gets two-cycle ERROR -> HTRANS=IDLE after first error cycle, one biu_err_o pulse, no ack for second read.
REQ-039 rst_ni=0 during data phase -> all outputs at reset values next edge, no ack/err after release.
REQ-040 HREADY=1 idle bus, no stb for 10 cycles -> HTRANS=IDLE, HSEL=0, no pulses.
